// File: rtl/shift_seq.sv
// Sequencer driving a single-step 8-bit rotate shifter across multiple cycles.
// It feeds each shifter result back as the next operand and returns the final value and carry.
module shift_seq #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_data,
    input  logic [CNT_W-1:0] req_cnt,
    input  logic             req_dir,
    output logic             fbus,
    output logic             flbus,
    output logic             frbus,
    output logic [7:0]       sh_a,
    input  logic [7:0]       sh_w,
    input  logic             sh_cf,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [7:0]       resp_data,
    output logic             resp_cf,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e           state_q;
    logic [7:0]       acc_q;
    logic [CNT_W-1:0] rem_q;
    logic             dir_q;
    logic             cf_q;

    // sh_w/sh_cf are only sampled in PASS/SHIFT, when the shifter is being strobed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= 8'h00;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            cf_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        acc_q   <= req_data;
                        rem_q   <= req_cnt;
                        dir_q   <= req_dir;
                        state_q <= (req_cnt == '0) ? S_PASS : S_SHIFT;
                    end
                end
                S_PASS: begin
                    acc_q   <= sh_w;
                    cf_q    <= 1'b0;
                    state_q <= S_DONE;
                end
                S_SHIFT: begin
                    acc_q <= sh_w;
                    cf_q  <= sh_cf;
                    if (rem_q != '0) begin
                        rem_q <= rem_q - ONE;
                    end
                    if (rem_q <= ONE) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    assign fbus       = (state_q == S_PASS);
    assign flbus      = (state_q == S_SHIFT) && !dir_q;
    assign frbus      = (state_q == S_SHIFT) &&  dir_q;
    assign sh_a       = acc_q;
    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign resp_data  = acc_q;
    assign resp_cf    = cf_q;

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: directed test-plan cases plus randomized requests,
// with a per-cycle compare against a transaction-level rotate model.
module tb_shift_seq;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [7:0]    req_data = 8'h00;
    logic [CW-1:0] req_cnt = '0;
    logic          req_dir = 1'b0;
    logic          fbus, flbus, frbus;
    logic [7:0]    sh_a;
    logic [7:0]    sh_w;
    logic          sh_cf;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [7:0]    resp_data;
    logic          resp_cf;
    logic          busy;

    logic [7:0]    junk_w = 8'h00;
    logic          junk_cf = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    shift_seq #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_cnt    (req_cnt),
        .req_dir    (req_dir),
        .fbus       (fbus),
        .flbus      (flbus),
        .frbus      (frbus),
        .sh_a       (sh_a),
        .sh_w       (sh_w),
        .sh_cf      (sh_cf),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_cf    (resp_cf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Single-step shifter; outside strobe cycles its outputs are garbage.
    assign sh_w  = fbus  ? sh_a :
                   flbus ? {sh_a[6:0], sh_a[7]} :
                   frbus ? {sh_a[0], sh_a[7:1]} : junk_w;
    assign sh_cf = flbus ? sh_a[7] : frbus ? sh_a[0] : junk_cf;

    always @(negedge clk) begin
        junk_w  <= 8'($urandom);
        junk_cf <= 1'($urandom);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 60)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference rotate of d by n steps, computed directly with arithmetic.
    function automatic logic [7:0] rot(input logic [7:0] d, input logic dir, input int n);
        int k;
        int dv;
        int v;
        k  = n % 8;
        dv = int'(d);
        if (k == 0) return d;
        if (dir) v = (dv >> k) | (dv << (8 - k));
        else     v = (dv << k) | (dv >> (8 - k));
        return v[7:0];
    endfunction

    function automatic logic cfexp(input logic [7:0] d, input logic dir, input int n);
        if (n == 0) return 1'b0;
        if (dir) return d[(n - 1) % 8];
        return d[(8 - (n % 8)) % 8];
    endfunction

    function automatic int steps(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    // Transaction-level model: cycles elapsed since accept decide the phase.
    logic       m_busy = 1'b0;
    logic [7:0] m_d = 8'h00;
    int         m_n = 0;
    logic       m_dir = 1'b0;
    int         m_k = 0;
    logic [7:0] m_last = 8'h00;
    logic       m_lastcf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   = 1'b0;
            m_k      = 0;
            m_last   = 8'h00;
            m_lastcf = 1'b0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_d    = req_data;
                m_n    = int'(req_cnt);
                m_dir  = req_dir;
                m_k    = 0;
                m_busy = 1'b1;
            end
        end else if (m_k >= steps(m_n) && resp_ready) begin
            m_busy   = 1'b0;
            m_last   = rot(m_d, m_dir, m_n);
            m_lastcf = cfexp(m_d, m_dir, m_n);
        end else begin
            m_k++;
        end
    end

    always @(negedge clk) begin
        if (!m_busy) begin
            chk("idle_ready", int'(req_ready), 1);
            chk("idle_busy", int'(busy), 0);
            chk("idle_rvalid", int'(resp_valid), 0);
            chk("idle_strobes", int'({fbus, flbus, frbus}), 0);
            chk("idle_sh_a", int'(sh_a), int'(m_last));
            chk("idle_rdata", int'(resp_data), int'(m_last));
            chk("idle_rcf", int'(resp_cf), int'(m_lastcf));
        end else if (m_k < steps(m_n)) begin
            chk("step_ready", int'(req_ready), 0);
            chk("step_busy", int'(busy), 1);
            chk("step_rvalid", int'(resp_valid), 0);
            if (m_n == 0) chk("step_strobes", int'({fbus, flbus, frbus}), 3'b100);
            else          chk("step_strobes", int'({fbus, flbus, frbus}), m_dir ? 3'b001 : 3'b010);
            chk("step_sh_a", int'(sh_a), int'(rot(m_d, m_dir, m_k)));
        end else begin
            chk("resp_ready_lo", int'(req_ready), 0);
            chk("resp_busy", int'(busy), 1);
            chk("resp_rvalid", int'(resp_valid), 1);
            chk("resp_strobes", int'({fbus, flbus, frbus}), 0);
            chk("resp_data", int'(resp_data), int'(rot(m_d, m_dir, m_n)));
            chk("resp_cf", int'(resp_cf), int'(cfexp(m_d, m_dir, m_n)));
        end
    end

    logic [7:0] seq [16];
    int         nstr;

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_req(input logic [7:0] d, input int n, input logic dir,
                           input logic [7:0] ed, input logic ecf, input int elat,
                           input int stall, input bit junk);
        int lat;
        req_data   = d;
        req_cnt    = n[CW-1:0];
        req_dir    = dir;
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        if (junk) begin
            req_data = 8'($urandom);
            req_cnt  = CW'($urandom);
            req_dir  = 1'($urandom);
        end else begin
            req_valid = 1'b0;
        end
        lat  = 0;
        nstr = 0;
        @(negedge clk);
        while (!resp_valid && lat < 40) begin
            if ((fbus | flbus | frbus) && nstr < 16) begin
                seq[nstr] = sh_a;
                nstr++;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, elat);
        chk("strobe_cycles", nstr, steps(n));
        chk("final_data", int'(resp_data), int'(ed));
        chk("final_cf", int'(resp_cf), int'(ecf));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", int'(resp_valid), 1);
            chk("stall_data", int'(resp_data), int'(ed));
            chk("stall_cf", int'(resp_cf), int'(ecf));
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        @(negedge clk);
        chk("ready_after_hs", int'(req_ready), 1);
    endtask

    initial begin
        int rv_seen;
        int n;
        logic [7:0] d;
        logic dir;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_rvalid", int'(resp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_strobes", int'({fbus, flbus, frbus}), 0);
        chk("rst_sh_a", int'(sh_a), 0);
        chk("rst_rdata", int'(resp_data), 0);
        chk("rst_rcf", int'(resp_cf), 0);
        #2 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_strobes_lit", int'({fbus, flbus, frbus}), 0);
            chk("idle_ready_lit", int'(req_ready), 1);
        end

        run_req(8'h81, 1, 1'b1, 8'hC0, 1'b1, 1, 0, 0);
        run_req(8'h96, 2, 1'b1, 8'hA5, 1'b1, 2, 0, 0);
        run_req(8'h96, 3, 1'b0, 8'hB4, 1'b0, 3, 0, 0);
        chk("seq0", int'(seq[0]), 8'h96);
        chk("seq1", int'(seq[1]), 8'h2D);
        chk("seq2", int'(seq[2]), 8'h5A);
        run_req(8'h3C, 0, 1'b0, 8'h3C, 1'b0, 1, 0, 0);
        run_req(8'h3C, 8, 1'b0, 8'h3C, 1'b0, 8, 0, 0);
        run_req(8'h96, 2, 1'b1, 8'hA5, 1'b1, 2, 4, 1);
        run_req(8'h3C, 0, 1'b1, 8'h3C, 1'b0, 1, 4, 1);

        // Reset in the second SHIFT cycle of a cnt=5 request.
        req_data  = 8'h5A;
        req_cnt   = CW'(5);
        req_dir   = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_rst_frbus", int'(frbus), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_strobes", int'({fbus, flbus, frbus}), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_ready", int'(req_ready), 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        rv_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid) rv_seen++;
        end
        chk("no_resp_after_rst", rv_seen, 0);
        run_req(8'h01, 1, 1'b0, 8'h02, 1'b0, 1, 0, 0);

        for (int t = 0; t < 80; t++) begin
            d   = 8'($urandom);
            n   = int'($urandom_range(0, 15));
            dir = 1'($urandom);
            run_req(d, n, dir, rot(d, dir, n), cfexp(d, dir, n), steps(n),
                    int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-step sequencer for the single-step 8-bit shifter in the CPU datapath. It accepts a rotate request (operand, direction, step count) over a valid/ready handshake. It then drives the shifter's one-hot control strobes (`fbus`, `flbus`, `frbus`) and operand bus once per cycle, feeding each result back as the next operand. When the count is exhausted it returns the final value and carry on a valid/ready response port. It sits between the control unit and the shifter and owns the shifter's control inputs exclusively.

## Interface
- `CNT_W`, default 3: width of the step count; maximum rotate is 2^CNT_W − 1.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request; high only in IDLE.
- `req_data`  in  8  operand.
- `req_cnt`  in  CNT_W  number of 1-bit rotate steps; 0 means pass-through.
- `req_dir`  in  1  0 = rotate left (`flbus`), 1 = rotate right (`frbus`).
- `fbus` / `flbus` / `frbus`  out  1 each  shifter control strobes; at most one high.
- `sh_a`  out  8  shifter operand input.
- `sh_w`  in  8  shifter result.
- `sh_cf`  in  1  shifter carry.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes the result.
- `resp_data`  out  8  final rotated value.
- `resp_cf`  out  1  carry from the last step; 0 for pass-through.
- `busy`  out  1  high in PASS, SHIFT, DONE.

## Operation
- State machine IDLE → (PASS | SHIFT) → DONE → IDLE. Encoding is free.
- **IDLE**
  - `req_ready` = 1 and all strobes are 0.
  - On `req_valid`: latch `req_data` into `acc`, `req_cnt` into `rem`, and `req_dir` into `dir`.
  - Next state is PASS if `req_cnt` == 0, else SHIFT.
- **PASS**
  - `fbus` = 1, `sh_a` = `acc`.
  - At the edge, `acc` ← `sh_w`, `cf_r` ← 0, next state DONE.
- **SHIFT**
  - `sh_a` = `acc`; `frbus` = `dir`, `flbus` = !`dir`.
  - At each edge: `acc` ← `sh_w`, `cf_r` ← `sh_cf`, `rem` ← `rem` − 1.
  - When `rem` == 1 at the edge, next state is DONE. `rem` never wraps below 0.
- **DONE**
  - `resp_valid` = 1; `resp_data` = `acc` and `resp_cf` = `cf_r`, both stable until the handshake.
  - On `resp_ready`, next state IDLE.
- Strobes are combinational from state and `dir`. Exactly one strobe is high in PASS/SHIFT; all are 0 in IDLE/DONE, where the shifter output is undriven.
- `sh_w` and `sh_cf` are sampled only in PASS/SHIFT; Z/X on them in other states must not affect any register.
- `req_*` inputs are ignored outside IDLE.
- Resulting carry:
  - Right rotate by N: `resp_cf` = original bit N−1.
  - Left rotate by N: `resp_cf` = original bit 8−N.
  - N ≥ 8 wraps naturally; a multiple of 8 returns the original data.
- Reset (any state, any time):
  - Asynchronously forces IDLE and clears `acc`, `rem`, `dir`, `cf_r`.
  - The in-flight request is discarded with no response.

## Timing
- Reset values:
  - `req_ready` = 1.
  - `resp_valid`, `busy`, `fbus`, `flbus`, `frbus` = 0.
  - `sh_a`, `resp_data` = 0x00; `resp_cf` = 0.
- Request accepted at the edge where `req_valid` && `req_ready`.
- Latency from the accept edge to `resp_valid` high:
  - N edges for `req_cnt` = N ≥ 1.
  - 1 edge for `req_cnt` = 0.
- `resp_valid` stays high, with data held, while `resp_ready` = 0.
- `req_ready` rises the cycle after the response handshake edge, so back-to-back issue costs one IDLE cycle. Request and response handshakes never occur in the same cycle.
- Peak throughput is one request per N+2 cycles.

## Test plan
- Reset/idle:
  - Hold `rst_n` = 0 → all outputs at their reset values.
  - Release with `req_valid` = 0 for 5 cycles → strobes stay 0 and `req_ready` = 1.
- Right rotate:
  - Request `req_data` = 0x81, cnt = 1, dir = 1 → `frbus` high for 1 cycle; `resp_data` = 0xC0, `resp_cf` = 1 one edge after accept.
  - Request 0x96, cnt = 2, dir = 1 → `resp_data` = 0xA5, `resp_cf` = 1 after 2 edges.
- Left rotate:
  - Request 0x96, cnt = 3, dir = 0 → `flbus` high for exactly 3 cycles with `sh_a` sequence 0x96, 0x2D, 0x5A.
  - Response is 0xB4, `resp_cf` = 0.
- Pass-through:
  - Request 0x3C, cnt = 0 → `fbus` high for 1 cycle; `resp_data` = 0x3C, `resp_cf` = 0.
  - With `CNT_W` = 4, cnt = 8, dir = 0 on 0x3C → `resp_data` = 0x3C, `resp_cf` = 0.
- Backpressure and ignore:
  - Hold `resp_ready` = 0 for 4 cycles → `resp_valid` and data remain stable.
  - Assert `req_valid` with new data during SHIFT/DONE → the new data is ignored.
  - After the handshake → `req_ready` = 1 next cycle and the new request is accepted.
- Reset mid-operation:
  - Assert `rst_n` = 0 asynchronously during the 2nd SHIFT cycle of a cnt = 5 request → strobes drop immediately.
  - No `resp_valid` ever appears for that request.
  - A following request of 0x01, cnt = 1, dir = 0 → 0x02, `resp_cf` = 0.
